// File: rtl/cnt1_stream.sv
// Streaming popcount stage: counts set (or clear) bits per multi-beat vector, with
// backpressure, bubble collapsing and framing checks against up_Last.
module cnt1_stream #(
  parameter int unsigned VECTOR_WIDTH  = 920,
  parameter int unsigned BUS_WIDTH     = 128,
  parameter int unsigned SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int unsigned POP_STAGES    = 2,
  parameter int unsigned COUNT_ZEROS   = 0,
  parameter int unsigned CNT_WIDTH     = $clog2(VECTOR_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] up_Vector,
  input  logic                 up_Valid,
  input  logic                 up_Last,
  output logic                 up_Ready,
  output logic [BUS_WIDTH-1:0] dn_SubVector,
  output logic                 dn_Valid,
  output logic [CNT_WIDTH-1:0] dn_Cnt,
  output logic                 dn_CntNew,
  output logic                 dn_Last,
  output logic                 dn_FrameErr,
  input  logic                 dn_Ready
);

  localparam int unsigned D        = POP_STAGES + 1;
  localparam int unsigned SumW     = $clog2(BUS_WIDTH + 1);
  localparam int unsigned AccW     = (CNT_WIDTH > SumW) ? CNT_WIDTH : SumW;
  localparam int unsigned WcW      = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int unsigned MaxG     = 1 << (POP_STAGES - 1);
  localparam int unsigned GrpW     = (BUS_WIDTH + MaxG - 1) / MaxG;
  localparam int unsigned LastBits = VECTOR_WIDTH - (SUB_VECTOR_NO - 1) * BUS_WIDTH;

  localparam logic [BUS_WIDTH-1:0] LastMask = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - LastBits);
  localparam logic [WcW-1:0]       LastWord = WcW'(SUB_VECTOR_NO - 1);

  logic [D:0]           en;
  logic [D-1:0]         valid_q, first_q, vlast_q, last_q, ferr_q;
  logic [BUS_WIDTH-1:0] data_q [D];
  logic [SumW-1:0]      psum_q [POP_STAGES][MaxG];
  logic [SumW-1:0]      psum_d [POP_STAGES][MaxG];
  logic [WcW-1:0]       wcnt_q, wcnt_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [SumW-1:0]      word_sum;
  logic [BUS_WIDTH-1:0] cnt_data;
  logic                 is_last_word;
  logic                 accept;

  // A stage may load whenever it is empty or its successor is loading, so bubbles collapse.
  always_comb begin
    en    = '0;
    en[D] = dn_Ready;
    for (int i = D - 1; i >= 0; i--) begin
      en[i] = ~valid_q[i] | en[i+1];
    end
  end

  always_comb begin
    is_last_word = (wcnt_q == LastWord);
    cnt_data     = (COUNT_ZEROS != 0) ? ~up_Vector : up_Vector;
    if (is_last_word) begin
      cnt_data = cnt_data & LastMask;
    end
    for (int s = 0; s < POP_STAGES; s++) begin
      for (int g = 0; g < MaxG; g++) begin
        psum_d[s][g] = '0;
      end
    end
    // First tree level: MaxG group popcounts; later levels add pairs.
    for (int g = 0; g < MaxG; g++) begin
      for (int b = 0; b < GrpW; b++) begin
        if (g * GrpW + b < BUS_WIDTH) begin
          psum_d[0][g] = psum_d[0][g] + SumW'(cnt_data[g*GrpW+b]);
        end
      end
    end
    for (int s = 1; s < POP_STAGES; s++) begin
      for (int g = 0; g < (MaxG >> s); g++) begin
        psum_d[s][g] = psum_q[s-1][2*g] + psum_q[s-1][2*g+1];
      end
    end
  end

  always_comb begin
    accept = up_Valid & en[0];
    wcnt_d = wcnt_q;
    if (accept) begin
      wcnt_d = (up_Last || is_last_word) ? '0 : wcnt_q + 1'b1;
    end
    word_sum = psum_q[POP_STAGES-1][0];
    acc_d    = first_q[D-2] ? AccW'(word_sum) : acc_q + AccW'(word_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      first_q <= '0;
      vlast_q <= '0;
      last_q  <= '0;
      ferr_q  <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      for (int i = 0; i < D; i++) begin
        data_q[i] <= '0;
      end
      for (int s = 0; s < POP_STAGES; s++) begin
        for (int g = 0; g < MaxG; g++) begin
          psum_q[s][g] <= '0;
        end
      end
    end else begin
      wcnt_q <= wcnt_d;
      // Tags are gated with up_Valid so bubbles never carry stale framing flags.
      if (en[0]) begin
        valid_q[0] <= up_Valid;
        data_q[0]  <= up_Vector;
        first_q[0] <= up_Valid & (wcnt_q == '0);
        vlast_q[0] <= up_Valid & (is_last_word | up_Last);
        last_q[0]  <= up_Valid & up_Last;
        ferr_q[0]  <= up_Valid & (up_Last ^ is_last_word);
      end
      for (int i = 1; i < D; i++) begin
        if (en[i]) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
          first_q[i] <= first_q[i-1];
          vlast_q[i] <= vlast_q[i-1];
          last_q[i]  <= last_q[i-1];
          ferr_q[i]  <= ferr_q[i-1];
        end
      end
      for (int s = 0; s < POP_STAGES; s++) begin
        if (en[s]) begin
          for (int g = 0; g < MaxG; g++) begin
            psum_q[s][g] <= psum_d[s][g];
          end
        end
      end
      if (en[D-1] && valid_q[D-2]) begin
        acc_q <= acc_d;
      end
    end
  end

  assign up_Ready     = en[0];
  assign dn_SubVector = data_q[D-1];
  assign dn_Valid     = valid_q[D-1];
  assign dn_Cnt       = acc_q[CNT_WIDTH-1:0];
  assign dn_CntNew    = vlast_q[D-1];
  assign dn_Last      = last_q[D-1];
  assign dn_FrameErr  = ferr_q[D-1];

endmodule

// File: tb/tb_cnt1_stream.sv
// Directed bench for cnt1_stream (920/128, 2 pop stages); a second instance counts zeros.
module tb_cnt1_stream;

  localparam logic [127:0] LMask = {104'd0, 24'hFF_FFFF};

  typedef struct packed {
    logic [127:0] data;
    logic         cntnew;
    logic [9:0]   cnt;
    logic [9:0]   zcnt;
    logic         last;
    logic         ferr;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] up_Vector = '0;
  logic         up_Valid = 1'b0;
  logic         up_Last = 1'b0;
  logic         up_Ready, z_up_Ready;
  logic [127:0] dn_SubVector, z_dn_SubVector;
  logic         dn_Valid, z_dn_Valid;
  logic [9:0]   dn_Cnt, z_dn_Cnt;
  logic         dn_CntNew, z_dn_CntNew;
  logic         dn_Last, z_dn_Last;
  logic         dn_FrameErr, z_dn_FrameErr;
  logic         dn_Ready;
  logic         rand_mode = 1'b0;
  logic         rnd_rdy = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_beats = 0;
  bit   lat_chk = 1'b0;
  exp_t q[$];
  logic [9:0] cnt_hist[$];
  logic [9:0] zcnt_hist[$];
  logic       ferr_hist[$];
  int         m_widx = 0;
  int         m_acc = 0;
  int         m_zacc = 0;

  logic         hold_pend = 1'b0;
  logic [127:0] hold_data;
  logic [9:0]   hold_cnt;
  logic [2:0]   hold_flags;

  assign dn_Ready = rand_mode ? rnd_rdy : 1'b1;

  cnt1_stream u_dut (
    .clk          (clk),
    .rst          (rst),
    .up_Vector    (up_Vector),
    .up_Valid     (up_Valid),
    .up_Last      (up_Last),
    .up_Ready     (up_Ready),
    .dn_SubVector (dn_SubVector),
    .dn_Valid     (dn_Valid),
    .dn_Cnt       (dn_Cnt),
    .dn_CntNew    (dn_CntNew),
    .dn_Last      (dn_Last),
    .dn_FrameErr  (dn_FrameErr),
    .dn_Ready     (dn_Ready)
  );

  cnt1_stream #(.COUNT_ZEROS(1)) u_dut_z (
    .clk          (clk),
    .rst          (rst),
    .up_Vector    (up_Vector),
    .up_Valid     (up_Valid),
    .up_Last      (up_Last),
    .up_Ready     (z_up_Ready),
    .dn_SubVector (z_dn_SubVector),
    .dn_Valid     (z_dn_Valid),
    .dn_Cnt       (z_dn_Cnt),
    .dn_CntNew    (z_dn_CntNew),
    .dn_Last      (z_dn_Last),
    .dn_FrameErr  (z_dn_FrameErr),
    .dn_Ready     (dn_Ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard compare, hold rule, ready invariant.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        assert (dn_Valid === 1'b1 && dn_SubVector === hold_data && dn_Cnt === hold_cnt &&
                {dn_CntNew, dn_Last, dn_FrameErr} === hold_flags)
        else begin
          errors++;
          $error("FAIL hold: observed cnt=%0d flags=%b expected cnt=%0d flags=%b",
                 dn_Cnt, {dn_CntNew, dn_Last, dn_FrameErr}, hold_cnt, hold_flags);
        end
      end
      hold_pend  = dn_Valid && !dn_Ready;
      hold_data  = dn_SubVector;
      hold_cnt   = dn_Cnt;
      hold_flags = {dn_CntNew, dn_Last, dn_FrameErr};
      checks++;
      assert (!dn_Ready || up_Ready === 1'b1)
      else begin
        errors++;
        $error("FAIL ready_inv: observed up_Ready=%b expected 1 with dn_Ready=1", up_Ready);
      end
      if (dn_Valid === 1'b1 && dn_Ready) begin
        n_beats++;
        checks++;
        assert (q.size() != 0)
        else begin
          errors++;
          $error("FAIL extra_beat: observed beat %0h expected none", dn_SubVector);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          checks++;
          assert (dn_SubVector === e.data)
          else begin
            errors++;
            $error("FAIL data: observed %h expected %h", dn_SubVector, e.data);
          end
          checks++;
          assert ({dn_CntNew, dn_Last, dn_FrameErr} === {e.cntnew, e.last, e.ferr})
          else begin
            errors++;
            $error("FAIL flags: observed new/last/ferr=%b expected %b",
                   {dn_CntNew, dn_Last, dn_FrameErr}, {e.cntnew, e.last, e.ferr});
          end
          checks++;
          assert (dn_Cnt === e.cnt && z_dn_Cnt === e.zcnt)
          else begin
            errors++;
            $error("FAIL cnt: observed %0d/%0d expected %0d/%0d", dn_Cnt, z_dn_Cnt, e.cnt,
                   e.zcnt);
          end
          checks++;
          assert (z_dn_Valid === 1'b1 && z_dn_SubVector === dn_SubVector &&
                  z_dn_CntNew === dn_CntNew && z_dn_Last === dn_Last &&
                  z_dn_FrameErr === dn_FrameErr && z_up_Ready === up_Ready)
          else begin
            errors++;
            $error("FAIL zinst: observed valid=%b new=%b expected valid=1 new=%b", z_dn_Valid,
                   z_dn_CntNew, dn_CntNew);
          end
          if (e.chk_lat) begin
            checks++;
            assert (cyc - e.acc_cyc == 3)
            else begin
              errors++;
              $error("FAIL latency: observed %0d expected 3", cyc - e.acc_cyc);
            end
          end
          if (e.cntnew) begin
            cnt_hist.push_back(dn_Cnt);
            zcnt_hist.push_back(z_dn_Cnt);
            ferr_hist.push_back(dn_FrameErr);
          end
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic last, input bit gap);
    int   n;
    bit   lw;
    exp_t e;
    up_Vector = d;
    up_Valid  = 1'b1;
    up_Last   = last;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (up_Ready !== 1'b1 && n < 200);
    checks++;
    assert (up_Ready === 1'b1)
    else begin
      errors++;
      $error("FAIL accept_timeout: observed up_Ready=%b expected 1", up_Ready);
    end
    lw = (m_widx == 7);
    m_acc  = ((m_widx == 0) ? 0 : m_acc) + $countones(lw ? (d & LMask) : d);
    m_zacc = ((m_widx == 0) ? 0 : m_zacc) + $countones(lw ? (~d & LMask) : ~d);
    e.data    = d;
    e.cntnew  = lw | last;
    e.ferr    = lw ^ last;
    e.last    = last;
    e.cnt     = 10'(m_acc);
    e.zcnt    = 10'(m_zacc);
    e.acc_cyc = cyc;
    e.chk_lat = lat_chk;
    q.push_back(e);
    m_widx = (last || lw) ? 0 : m_widx + 1;
    @(posedge clk);
    #1;
    up_Valid = 1'b0;
    up_Last  = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (q.size() == 0)
    else begin
      errors++;
      $error("FAIL drain: observed %0d beats pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    cnt_hist.delete();
    zcnt_hist.delete();
    ferr_hist.delete();
  endtask

  task automatic check_vec(input string tag, input int idx, input logic [9:0] c,
                           input logic [9:0] zc, input logic fe);
    checks++;
    assert (cnt_hist.size() > idx && cnt_hist[idx] === c && zcnt_hist[idx] === zc &&
            ferr_hist[idx] === fe)
    else begin
      errors++;
      if (cnt_hist.size() > idx)
        $error("FAIL %s: observed cnt=%0d zcnt=%0d ferr=%b expected %0d %0d %b", tag,
               cnt_hist[idx], zcnt_hist[idx], ferr_hist[idx], c, zc, fe);
      else $error("FAIL %s: observed %0d vectors expected more than %0d", tag,
                  cnt_hist.size(), idx);
    end
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] w0;
    int           b0;
    ones = '1;
    w0   = 128'hFF;

    #12;
    checks++;
    assert ({dn_Valid, dn_CntNew, dn_Last, dn_FrameErr} === 4'b0 && dn_Cnt === 10'd0 &&
            dn_SubVector === 128'd0)
    else begin
      errors++;
      $error("FAIL reset: observed valid=%b cnt=%0d expected 0", dn_Valid, dn_Cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // All-ones vector: padding ignored, latency checked.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(ones, i == 7, 1'b0);
    drain();
    checks++;
    assert (cnt_hist.size() == 1 && n_beats == 8)
    else begin
      errors++;
      $error("FAIL ones_vecs: observed %0d vectors %0d beats expected 1 8", cnt_hist.size(),
             n_beats);
    end
    check_vec("ones", 0, 10'd920, 10'd0, 1'b0);

    // Sparse pattern, two vectors back to back.
    clear_hist();
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 8; i++) send((i == 0) ? w0 : ((i == 7) ? ones : '0), i == 7, 1'b0);
    end
    drain();
    check_vec("sparse0", 0, 10'd32, 10'd888, 1'b0);
    check_vec("sparse1", 1, 10'd32, 10'd888, 1'b0);

    // Valid toggling with random backpressure.
    lat_chk   = 1'b0;
    rand_mode = 1'b1;
    clear_hist();
    b0 = n_beats;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 8; i++) begin
        send({$urandom(), $urandom(), $urandom(), $urandom()}, i == 7, 1'b1);
      end
    end
    drain();
    rand_mode = 1'b0;
    checks++;
    assert (n_beats - b0 == 40 && cnt_hist.size() == 5)
    else begin
      errors++;
      $error("FAIL rand_beats: observed %0d beats %0d vectors expected 40 5", n_beats - b0,
             cnt_hist.size());
    end

    // Early up_Last, then full vector, then missing up_Last.
    clear_hist();
    for (int i = 0; i < 3; i++) send(ones, i == 2, 1'b0);
    for (int i = 0; i < 8; i++) send(ones, i == 7, 1'b0);
    for (int i = 0; i < 8; i++) send(ones, 1'b0, 1'b0);
    drain();
    check_vec("early_last", 0, 10'd384, 10'd0, 1'b1);
    check_vec("resync", 1, 10'd920, 10'd0, 1'b0);
    check_vec("missing_last", 2, 10'd920, 10'd0, 1'b1);

    // All-zero vector: zero counter gives 920, not 1024.
    clear_hist();
    for (int i = 0; i < 8; i++) send('0, i == 7, 1'b0);
    drain();
    check_vec("zeros", 0, 10'd0, 10'd920, 1'b0);

    // Asynchronous reset mid-vector.
    clear_hist();
    for (int i = 0; i < 4; i++) send(ones, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    assert ({dn_Valid, dn_CntNew, dn_Last, dn_FrameErr} === 4'b0 && dn_Cnt === 10'd0 &&
            dn_SubVector === 128'd0)
    else begin
      errors++;
      $error("FAIL async_rst: observed valid=%b cnt=%0d expected 0", dn_Valid, dn_Cnt);
    end
    q.delete();
    m_widx = 0;
    m_acc  = 0;
    m_zacc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) send((i == 0) ? w0 : ((i == 7) ? ones : '0), i == 7, 1'b0);
    drain();
    checks++;
    assert (cnt_hist.size() == 1)
    else begin
      errors++;
      $error("FAIL post_rst_vecs: observed %0d expected 1", cnt_hist.size());
    end
    check_vec("post_rst", 0, 10'd32, 10'd888, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
